// File: rtl/truth_table_sampler_pkg.sv
// Shared types and limits for the truth-table sampler and its settle timer.
package tt_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  // Largest supported DUT input count and settle hold time.
  localparam int TT_MAX_IN     = 4;
  localparam int TT_MAX_SETTLE = 15;

  // Number of truth-table entries for an n-input gate.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sampler_settle_timer.sv
// Loadable count-down timer. It sets how long each input vector is held
// before the DUT output is sampled. It stops at zero and flags it.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  // Load takes priority. Otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/truth_table_sampler.sv
// Sweeps every input combination of a small combinational DUT. It holds each
// vector for SETTLE cycles and then samples the DUT output into a truth-table
// word. When the sweep ends, it compares that word with a reference table
// latched at start.
module truth_table_sampler
  import tt_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [(1 << N_IN)-1:0]    expected,
  output logic                      busy,
  output logic                      done,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_out,
  output logic [(1 << N_IN)-1:0]    table_out,
  output logic                      match
);

  localparam int                TW          = tt_width(N_IN);
  localparam logic [N_IN-1:0]   LAST_VEC    = N_IN'(TW - 1);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE - 1);

  // Reject unsupported configurations while elaborating.
  if ((N_IN < 1) || (N_IN > TT_MAX_IN)) begin : g_bad_n_in
    $error("truth_table_sampler: N_IN out of range 1..%0d", TT_MAX_IN);
  end
  if ((SETTLE < 1) || (SETTLE > TT_MAX_SETTLE)) begin : g_bad_settle
    $error("truth_table_sampler: SETTLE out of range 1..%0d", TT_MAX_SETTLE);
  end

  tt_state_e          state_reg, state_next;
  logic [N_IN-1:0]    vec_reg, vec_next;
  logic [N_IN-1:0]    dut_in_reg, dut_in_next;
  logic [TW-1:0]      table_reg, table_next;
  logic [TW-1:0]      exp_reg, exp_next;
  logic               match_reg, match_next;
  logic               tmr_load, tmr_en, tmr_zero;

  tt_settle_timer #(.W(4)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Register the FSM state and the sweep datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      vec_reg    <= '0;
      dut_in_reg <= '0;
      table_reg  <= '0;
      exp_reg    <= '0;
      match_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      vec_reg    <= vec_next;
      dut_in_reg <= dut_in_next;
      table_reg  <= table_next;
      exp_reg    <= exp_next;
      match_reg  <= match_next;
    end
  end

  // Next-state logic: accept start, step through the vectors, and judge the table.
  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    table_next = table_reg;
    exp_next   = exp_reg;
    match_next = match_reg;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          vec_next   = '0;
          table_next = '0;
          match_next = 1'b0;
          exp_next   = expected;
          tmr_load   = 1'b1;
        end
      end
      RUN: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          table_next[vec_reg] = dut_out;
          if (vec_reg == LAST_VEC) begin
            state_next = DONE;
            // Compare against the table including the bit captured this cycle.
            match_next = (table_next == exp_reg);
          end else begin
            vec_next = vec_reg + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Drive the vector only while sweeping. It is parked at 0 otherwise.
    dut_in_next = (state_next == RUN) ? vec_next : '0;
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign dut_in    = dut_in_reg;
  assign table_out = table_reg;
  assign match     = match_reg;

endmodule

// File: tb/tb_truth_table_sampler.sv
// Self-checking bench for truth_table_sampler. Three instances sweep XOR,
// AND and inverter gates under different N_IN/SETTLE settings. A scoreboard
// queue per instance holds the expected tables.
module tb_truth_table_sampler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] tbl;
    logic       m;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // Instance A: 2-input XOR, SETTLE=2
  logic       start_a = 1'b0;
  logic [3:0] exp_a   = '0;
  logic       busy_a, done_a, match_a, dut_out_a;
  logic [1:0] dut_in_a;
  logic [3:0] table_a;
  assign dut_out_a = dut_in_a[1] ^ dut_in_a[0];

  truth_table_sampler #(.N_IN(2), .SETTLE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
    .busy(busy_a), .done(done_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .table_out(table_a), .match(match_a)
  );

  // Instance B: in3 & in1, SETTLE=1
  logic       start_b = 1'b0;
  logic [7:0] exp_b   = '0;
  logic       busy_b, done_b, match_b, dut_out_b;
  logic [2:0] dut_in_b;
  logic [7:0] table_b;
  assign dut_out_b = dut_in_b[2] & dut_in_b[0];

  truth_table_sampler #(.N_IN(3), .SETTLE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
    .busy(busy_b), .done(done_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .table_out(table_b), .match(match_b)
  );

  // Instance C: inverter, SETTLE=3
  logic       start_c = 1'b0;
  logic [1:0] exp_c   = '0;
  logic       busy_c, done_c, match_c, dut_out_c;
  logic [0:0] dut_in_c;
  logic [1:0] table_c;
  assign dut_out_c = ~dut_in_c[0];

  truth_table_sampler #(.N_IN(1), .SETTLE(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .expected(exp_c),
    .busy(busy_c), .done(done_c), .dut_in(dut_in_c), .dut_out(dut_out_c),
    .table_out(table_c), .match(match_c)
  );

  // Reference gate models, swept over every input combination.
  function automatic logic [7:0] model_xor2();
    logic [7:0] t = '0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] v = 2'(k);
      t[k] = v[1] ^ v[0];
    end
    return t;
  endfunction

  function automatic logic [7:0] model_and31();
    logic [7:0] t = '0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v = 3'(k);
      t[k] = v[2] & v[0];
    end
    return t;
  endfunction

  function automatic logic [7:0] model_inv1();
    logic [7:0] t = '0;
    for (int k = 0; k < 2; k++) begin
      logic v = k[0];
      t[k] = ~v;
    end
    return t;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy_a, done_a, dut_in_a, table_a, match_a} !== 9'h0) begin
      n_err++;
      $display("FAIL reset_a: got %h expected 0", {busy_a, done_a, dut_in_a, table_a, match_a});
    end
    n_vec++;
    if ({busy_b, done_b, dut_in_b, table_b, match_b} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_b: got %h expected 0", {busy_b, done_b, dut_in_b, table_b, match_b});
    end
    n_vec++;
    if ({busy_c, done_c, dut_in_c, table_c, match_c} !== 6'h0) begin
      n_err++;
      $display("FAIL reset_c: got %h expected 0", {busy_c, done_c, dut_in_c, table_c, match_c});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One XOR sweep on instance A. When poke is set, start is also pulsed
  // during RUN and during DONE, and neither pulse may have any effect.
  task automatic sweep_a(input bit poke, input string tag);
    exp_t e;
    int   busy_cnt = 0;
    int   done_cyc = 0;
    int   vec_bad  = 0;
    int   extra    = 0;
    e.tbl = model_xor2();
    e.m   = (e.tbl[3:0] == 4'b0110);
    q_a.push_back(e);
    exp_a   = 4'b0110;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (busy_a) begin
        busy_cnt++;
        if (dut_in_a !== 2'((c - 1) / 2)) vec_bad++;
      end
      if (done_a) begin
        done_cyc = c;
        break;
      end
      if (poke) start_a = (c == 3);
      @(negedge clk);
    end
    start_a = 1'b0;
    n_vec++;
    if (busy_cnt != 8) begin
      n_err++;
      $display("FAIL %s_busy_cycles: got %0d expected 8", tag, busy_cnt);
    end
    n_vec++;
    if (done_cyc != 9) begin
      n_err++;
      $display("FAIL %s_done_cycle: got %0d expected 9", tag, done_cyc);
    end
    n_vec++;
    if (vec_bad != 0) begin
      n_err++;
      $display("FAIL %s_vector_order: got %0d bad cycles expected 0", tag, vec_bad);
    end
    n_vec++;
    if (q_a.size() == 0) begin
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = q_a.pop_front();
      if (table_a !== e.tbl[3:0] || match_a !== e.m) begin
        n_err++;
        $display("FAIL %s_table: got table=%b match=%b expected table=%b match=%b",
                 tag, table_a, match_a, e.tbl[3:0], e.m);
      end
    end
    if (poke) begin
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int c = 0; c < 15; c++) begin
        if (busy_a || done_a) extra++;
        @(negedge clk);
      end
      n_vec++;
      if (extra != 0) begin
        n_err++;
        $display("FAIL %s_no_restart: got %0d active cycles expected 0", tag, extra);
      end
    end else begin
      @(negedge clk);
      n_vec++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || dut_in_a !== 2'd0) begin
        n_err++;
        $display("FAIL %s_idle_after: got busy=%b done=%b dut_in=%0d expected 0 0 0",
                 tag, busy_a, done_a, dut_in_a);
      end
    end
  endtask

  task automatic test_xor;
    sweep_a(1'b0, "xor");
  endtask

  task automatic test_ignore_start;
    sweep_a(1'b1, "ignore_start");
  endtask

  // One AND sweep on instance B against a given reference table.
  task automatic sweep_b(input logic [7:0] ref_tbl, input string tag);
    exp_t e;
    int   busy_cnt = 0;
    int   done_cyc = 0;
    int   vec_bad  = 0;
    e.tbl = model_and31();
    e.m   = (e.tbl == ref_tbl);
    q_b.push_back(e);
    exp_b   = ref_tbl;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (busy_b) begin
        busy_cnt++;
        if (dut_in_b !== 3'(c - 1)) vec_bad++;
      end
      if (done_b) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (done_cyc != 9 || busy_cnt != 8) begin
      n_err++;
      $display("FAIL %s_timing: got done at %0d busy %0d expected 9 and 8", tag, done_cyc, busy_cnt);
    end
    n_vec++;
    if (vec_bad != 0) begin
      n_err++;
      $display("FAIL %s_vector_order: got %0d bad cycles expected 0", tag, vec_bad);
    end
    n_vec++;
    if (q_b.size() == 0) begin
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = q_b.pop_front();
      if (table_b !== e.tbl || match_b !== e.m) begin
        n_err++;
        $display("FAIL %s_table: got table=%h match=%b expected table=%h match=%b",
                 tag, table_b, match_b, e.tbl, e.m);
      end
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (table_b !== e.tbl || match_b !== e.m || dut_in_b !== 3'd0) begin
      n_err++;
      $display("FAIL %s_hold: got table=%h match=%b dut_in=%0d expected table=%h match=%b dut_in=0",
               tag, table_b, match_b, dut_in_b, e.tbl, e.m);
    end
  endtask

  task automatic test_and_match;
    sweep_b(8'hA0, "and_match");
  endtask

  task automatic test_and_mismatch;
    sweep_b(8'hA1, "and_mismatch");
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    exp_a   = 4'b0110;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (dut_in_a == 2'd2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL reset_mid_reach_vec2: got timeout expected dut_in=2");
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy_a, done_a, dut_in_a, table_a, match_a} !== 9'h0) begin
      n_err++;
      $display("FAIL reset_mid_a: got %h expected 0", {busy_a, done_a, dut_in_a, table_a, match_a});
    end
    n_vec++;
    if ({table_b, match_b} !== 9'h0) begin
      n_err++;
      $display("FAIL reset_mid_b: got %h expected 0", {table_b, match_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep_a(1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   d[3];
    int   n_done   = 0;
    int   idle_bad = 0;
    int   gap_bad  = 0;
    int   last_c   = 0;
    e.tbl = model_inv1();
    e.m   = (e.tbl[1:0] == 2'b01);
    repeat (3) q_c.push_back(e);
    exp_c   = 2'b01;
    start_c = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 60; c++) begin
      if (!busy_c && dut_in_c !== 1'b0) idle_bad++;
      if (n_done > 0 && c == d[n_done-1] + 1 && (busy_c || done_c)) gap_bad++;
      if (done_c && n_done < 3) begin
        d[n_done] = c;
        n_done++;
        n_vec++;
        if (q_c.size() == 0) begin
          n_err++;
          $display("FAIL b2b_scoreboard: got empty queue expected one entry");
        end else begin
          e = q_c.pop_front();
          if (table_c !== e.tbl[1:0] || match_c !== e.m) begin
            n_err++;
            $display("FAIL b2b_table%0d: got table=%b match=%b expected table=%b match=%b",
                     n_done, table_c, match_c, e.tbl[1:0], e.m);
          end
        end
        if (n_done == 3) begin
          start_c = 1'b0;
          last_c  = c;
        end
      end
      if (n_done == 3 && c >= last_c + 2) break;
      @(negedge clk);
    end
    start_c = 1'b0;
    n_vec++;
    if (n_done != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d done pulses expected 3", n_done);
    end else begin
      n_vec++;
      if (d[0] != 7 || d[1] - d[0] != 8 || d[2] - d[1] != 8) begin
        n_err++;
        $display("FAIL b2b_period: got done at %0d %0d %0d expected 7 15 23", d[0], d[1], d[2]);
      end
    end
    n_vec++;
    if (idle_bad != 0 || gap_bad != 0) begin
      n_err++;
      $display("FAIL b2b_idle: got %0d nonzero dut_in and %0d bad gap cycles expected 0 0",
               idle_bad, gap_bad);
    end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_and_match();
    test_and_mismatch();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
